multicycle_controller: RTL



---
 rtl/multicycle_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multicycle RV32I datapath (lw, sw, R/I ALU, beq, jal).
// Define MC_WAITSTATE_EN to add a MemReady input that stalls FETCH/MEMREAD/MEMWRITE.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
`ifdef MC_WAITSTATE_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } state_e;

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  state_e     state_q, state_d;
  logic       mem_rdy;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

`ifdef MC_WAITSTATE_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = StFetch;
    pc_update = 1'b0;
    branch    = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    unique case (state_q)
      StFetch: begin
        // Fetch stalls with the IR/PC enables gated until memory answers.
        IRWrite   = mem_rdy;
        pc_update = mem_rdy;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = mem_rdy ? StDecode : StFetch;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecuteR;
          OpItype:    state_d = StExecuteI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        state_d = mem_rdy ? StMemWb : StMemRead;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = mem_rdy;
        state_d  = mem_rdy ? StFetch : StMemWrite;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = StAluWb;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StJal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign PCWrite = (branch & Zero) | pc_update;
  assign State   = state_q;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpSw:    ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder: subtract only for R-type with funct7b5 set; I-type addi never subtracts.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule
